// File: rtl/fixed_to_float_pipe.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : fixed_to_float_pipe
// Purpose : 3-stage fixed-point to IEEE-754 single-precision converter with
//           valid/ready handshaking on both sides (RNE rounding).
// Revision: 1.0 - initial release
// ============================================================================
module fixed_to_float_pipe #(
    parameter int IN_W   = 16,
    parameter int FRAC_W = 0,
    parameter int SIGNED = 1
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_valid,
    output logic            o_ready,
    input  logic [IN_W-1:0] i_fixed,
    output logic            o_valid,
    input  logic            i_ready,
    output logic [31:0]     o_float,
    output logic            o_inexact
);

    localparam int C_NORM_W = IN_W - 1;
    localparam int C_EXT_SH = 57 - IN_W;

    logic                en;

    logic                sign1_d, sign1_q, valid1_q;
    logic [IN_W-1:0]     mag1_d, mag1_q;

    logic [5:0]          lead2;
    logic [C_NORM_W-1:0] norm2_d, norm2_q;
    logic [7:0]          exp2_d, exp2_q;
    logic                zero2_d, zero2_q, sign2_q, valid2_q;

    logic [55:0]         ext3;
    logic [22:0]         mant3;
    logic                guard3, sticky3, round_up3;
    logic [23:0]         mant_r3;
    logic [7:0]          exp_r3;
    logic [31:0]         float3_d, float3_q;
    logic                inexact3_d, inexact3_q, valid3_q;

    // A full output register only blocks the pipe when downstream refuses it.
    assign en        = ~valid3_q | i_ready;
    assign o_ready   = en | i_rst;
    assign o_valid   = valid3_q;
    assign o_float   = float3_q;
    assign o_inexact = inexact3_q;

    // Stage 1: sign and IN_W-bit magnitude (most negative input stays exact).
    assign sign1_d = (SIGNED != 0) ? i_fixed[IN_W-1] : 1'b0;
    assign mag1_d  = sign1_d ? -i_fixed : i_fixed;

    // Stage 2: leading-one position and left normalisation.
    always_comb begin
        lead2 = '0;
        for (int i = 0; i < IN_W; i++) begin
            if (mag1_q[i]) lead2 = 6'(i);
        end
    end

    assign zero2_d = ~|mag1_q;
    assign norm2_d = C_NORM_W'(mag1_q << (6'(IN_W - 1) - lead2));
    assign exp2_d  = 8'(127 - FRAC_W) + {2'b00, lead2};

    // Stage 3: left-align fraction, round to nearest even, pack.
    assign ext3      = {norm2_q, {C_EXT_SH{1'b0}}};
    assign mant3     = ext3[55:33];
    assign guard3    = ext3[32];
    assign sticky3   = |ext3[31:0];
    assign round_up3 = guard3 & (sticky3 | mant3[0]);
    assign mant_r3   = {1'b0, mant3} + {23'd0, round_up3};
    assign exp_r3    = exp2_q + {7'd0, mant_r3[23]};

    assign float3_d   = zero2_q ? 32'h0000_0000 : {sign2_q, exp_r3, mant_r3[22:0]};
    assign inexact3_d = ~zero2_q & (guard3 | sticky3);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            valid1_q   <= 1'b0;
            sign1_q    <= 1'b0;
            mag1_q     <= '0;
            valid2_q   <= 1'b0;
            sign2_q    <= 1'b0;
            zero2_q    <= 1'b1;
            exp2_q     <= '0;
            norm2_q    <= '0;
            valid3_q   <= 1'b0;
            float3_q   <= '0;
            inexact3_q <= 1'b0;
        end else if (en) begin
            valid1_q   <= i_valid;
            sign1_q    <= sign1_d;
            mag1_q     <= mag1_d;
            valid2_q   <= valid1_q;
            sign2_q    <= sign1_q;
            zero2_q    <= zero2_d;
            exp2_q     <= exp2_d;
            norm2_q    <= norm2_d;
            valid3_q   <= valid2_q;
            float3_q   <= float3_d;
            inexact3_q <= inexact3_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fixed_to_float_pipe.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : tb_fixed_to_float_pipe
// Purpose : Scoreboarded bench for fixed_to_float_pipe in three configurations.
// Revision: 1.0 - initial release
// ============================================================================
module tb_fixed_to_float_pipe;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // A: IN_W=16 FRAC_W=0 signed; B: IN_W=16 FRAC_W=8 signed; C: IN_W=32 unsigned
    logic        a_valid, a_ready_o, a_ovalid, a_iready, a_inexact;
    logic [15:0] a_fixed;
    logic [31:0] a_float;
    logic        b_valid, b_ready_o, b_ovalid, b_iready, b_inexact;
    logic [15:0] b_fixed;
    logic [31:0] b_float;
    logic        c_valid, c_ready_o, c_ovalid, c_iready, c_inexact;
    logic [31:0] c_fixed;
    logic [31:0] c_float;

    logic [32:0] qa[$];
    logic [32:0] qb[$];
    logic [32:0] qc[$];

    fixed_to_float_pipe #(.IN_W(16), .FRAC_W(0), .SIGNED(1)) u_dut_a (
        .i_clk(clk), .i_rst(rst), .i_valid(a_valid), .o_ready(a_ready_o),
        .i_fixed(a_fixed), .o_valid(a_ovalid), .i_ready(a_iready),
        .o_float(a_float), .o_inexact(a_inexact));

    fixed_to_float_pipe #(.IN_W(16), .FRAC_W(8), .SIGNED(1)) u_dut_b (
        .i_clk(clk), .i_rst(rst), .i_valid(b_valid), .o_ready(b_ready_o),
        .i_fixed(b_fixed), .o_valid(b_ovalid), .i_ready(b_iready),
        .o_float(b_float), .o_inexact(b_inexact));

    fixed_to_float_pipe #(.IN_W(32), .FRAC_W(0), .SIGNED(0)) u_dut_c (
        .i_clk(clk), .i_rst(rst), .i_valid(c_valid), .o_ready(c_ready_o),
        .i_fixed(c_fixed), .o_valid(c_ovalid), .i_ready(c_iready),
        .o_float(c_float), .o_inexact(c_inexact));

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: exact value via double precision, then RNE down to 23 fraction bits.
    function automatic logic [32:0] model(input longint v, input int frac);
        real         r;
        real         scale;
        logic [63:0] b;
        logic [22:0] m;
        logic [23:0] s;
        logic        g, st, up;
        int          e;
        if (v == 0) return 33'd0;
        scale = 1.0;
        for (int i = 0; i < frac; i++) scale = scale * 2.0;
        r  = v;
        r  = r / scale;
        b  = $realtobits(r);
        e  = int'(b[62:52]) - 1023 + 127;
        m  = b[51:29];
        g  = b[28];
        st = |b[27:0];
        up = g & (st | m[0]);
        s  = {1'b0, m} + {23'd0, up};
        if (s[23]) e = e + 1;
        return {g | st, b[63], 8'(e), s[22:0]};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (rst) begin
            qa.delete();
            qb.delete();
            qc.delete();
        end else begin
            if (a_ovalid && a_iready) begin
                if (qa.size() == 0) check("a_unexpected_out", {31'd0, a_inexact, a_float}, 64'd0);
                else check("a_out", {31'd0, a_inexact, a_float}, {31'd0, qa.pop_front()});
            end
            if (a_valid && a_ready_o) qa.push_back(model(longint'($signed(a_fixed)), 0));
            if (b_ovalid && b_iready) begin
                if (qb.size() == 0) check("b_unexpected_out", {31'd0, b_inexact, b_float}, 64'd0);
                else check("b_out", {31'd0, b_inexact, b_float}, {31'd0, qb.pop_front()});
            end
            if (c_ovalid && c_iready) begin
                if (qc.size() == 0) check("c_unexpected_out", {31'd0, c_inexact, c_float}, 64'd0);
                else check("c_out", {31'd0, c_inexact, c_float}, {31'd0, qc.pop_front()});
            end
        end
    end

    logic [15:0] vin_a [5];
    logic [31:0] vexp_a[5];
    logic [31:0] vin_c [5];
    logic [32:0] vexp_c[5];
    logic [32:0] held;
    logic [31:0] rv;

    initial begin
        rst = 1'b1;
        a_valid = 1'b0; a_fixed = '0; a_iready = 1'b1;
        b_valid = 1'b0; b_fixed = '0; b_iready = 1'b1;
        c_valid = 1'b0; c_fixed = '0; c_iready = 1'b1;
        vin_a  = '{16'h0001, 16'hFFFF, 16'h0000, 16'h7FFF, 16'h8000};
        vexp_a = '{32'h3F80_0000, 32'hBF80_0000, 32'h0000_0000, 32'h46FF_FE00, 32'hC700_0000};
        vin_c  = '{32'h0100_0001, 32'h0100_0003, 32'h01FF_FFFF, 32'hFFFF_FFFF, 32'h0000_0005};
        vexp_c = '{{1'b1, 32'h4B80_0000}, {1'b1, 32'h4B80_0002}, {1'b1, 32'h4C00_0000},
                   {1'b1, 32'h4F80_0000}, {1'b0, 32'h40A0_0000}};

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_ovalid",  {63'd0, a_ovalid}, 64'd0);
        check("rst_float",   {32'd0, a_float}, 64'd0);
        check("rst_inexact", {63'd0, a_inexact}, 64'd0);
        check("rst_oready",  {63'd0, a_ready_o}, 64'd1);
        check("rst_ovalid_c", {63'd0, c_ovalid}, 64'd0);
        @(posedge clk);
        #1 rst = 1'b0;

        // Back-to-back directed samples; results must appear on cycles 3..7.
        for (int cyc = 0; cyc < 8; cyc++) begin
            a_valid = (cyc < 5);
            if (cyc < 5) a_fixed = vin_a[cyc];
            @(negedge clk);
            if (cyc == 0) check("ready_after_rst", {63'd0, a_ready_o}, 64'd1);
            if (cyc < 3) begin
                check("lat_idle", {63'd0, a_ovalid}, 64'd0);
            end else begin
                check("lat_valid", {63'd0, a_ovalid}, 64'd1);
                check("seq_out", {31'd0, a_inexact, a_float}, {32'd0, vexp_a[cyc-3]});
            end
            @(posedge clk);
            #1;
        end
        a_valid = 1'b0;

        // Fractional input configuration.
        b_valid = 1'b1;
        qb.push_back({1'b0, 32'h3FC0_0000}); b_fixed = 16'h0180; tick();
        qb.push_back({1'b0, 32'hBFC0_0000}); b_fixed = 16'hFE80; tick();
        qb.push_back({1'b0, 32'h3B80_0000}); b_fixed = 16'h0001; tick();
        b_valid = 1'b0;

        // Wide unsigned configuration: rounding, ties-to-even, carry into exponent.
        c_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            qc.push_back(vexp_c[i]);
            c_fixed = vin_c[i];
            tick();
        end
        c_valid = 1'b0;
        repeat (6) tick();

        // Backpressure: full pipe, downstream stalled for 4 cycles.
        a_iready = 1'b1;
        a_valid  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            a_fixed = 16'($urandom);
            tick();
        end
        a_iready = 1'b0;
        for (int s = 0; s < 4; s++) begin
            a_fixed = 16'($urandom);
            @(negedge clk);
            check("stall_oready", {63'd0, a_ready_o}, 64'd0);
            check("stall_ovalid", {63'd0, a_ovalid}, 64'd1);
            if (s == 0) held = {a_inexact, a_float};
            else check("stall_hold", {31'd0, a_inexact, a_float}, {31'd0, held});
            @(posedge clk);
            #1;
        end
        a_iready = 1'b1;
        a_valid  = 1'b0;
        repeat (6) tick();
        check("stall_drain", 64'(qa.size()), 64'd0);

        // Reset with two samples in flight.
        a_valid = 1'b1;
        for (int i = 0; i < 2; i++) begin
            a_fixed = 16'($urandom);
            tick();
        end
        a_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("rst_flush_ovalid", {63'd0, a_ovalid}, 64'd0);
        check("rst_flush_oready", {63'd0, a_ready_o}, 64'd1);
        @(posedge clk);
        #1;
        repeat (6) tick();

        // Random stream with random downstream readiness.
        for (int i = 0; i < 400; i++) begin
            a_valid  = ($urandom_range(0, 3) != 0);
            a_iready = ($urandom_range(0, 3) != 0);
            case ($urandom_range(0, 9))
                0:       a_fixed = 16'h8000;
                1:       a_fixed = 16'h7FFF;
                2:       a_fixed = 16'h0000;
                default: a_fixed = 16'($urandom);
            endcase
            tick();
        end
        a_valid  = 1'b0;
        a_iready = 1'b1;
        repeat (8) tick();
        check("rand_drain_a", 64'(qa.size()), 64'd0);

        // Random wide unsigned samples spanning all leading-one positions.
        c_valid = 1'b1;
        for (int i = 0; i < 200; i++) begin
            rv = $urandom;
            rv = rv >> $urandom_range(0, 31);
            c_fixed = rv;
            qc.push_back(model(longint'({32'd0, rv}), 0));
            tick();
        end
        c_valid = 1'b0;
        repeat (8) tick();
        check("drain_b", 64'(qb.size()), 64'd0);
        check("drain_c", 64'(qc.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
